// File: rtl/snitch_ptw.sv
// Sv32 page-table walker: refills the L0 TLB through a single-outstanding memory port.
// Define SNITCH_PTW_PTR_CACHE_EN to add a one-entry cache of the last level-1 pointer PTE.
`timescale 1ns/1ps
module snitch_ptw #(
    parameter int unsigned PLEN      = 34,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [21:0]          satp_ppn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          va_i,
    output logic [31:0]          pte_o,
    output logic                 is_4mega_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [PLEN-1:0]      mem_addr_o,
    input  logic                 mem_rsp_valid_i,
    input  logic [DataWidth-1:0] mem_rsp_data_i,
    input  logic                 mem_rsp_error_i
);

    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE} state_e;

    localparam logic [31:0] ABitMask = 32'h0000_0040;

    state_e          state_q;
    logic [9:0]      vpn0_q;
    logic [31:0]     pte_q;
    logic            is_4mega_q;
    logic            abort_q;
    logic            mem_valid_q;
    logic            ready_q;
    logic [PLEN-1:0] mem_addr_q;

    // The page offset never takes part in a walk.
    logic unused_va_offset;
    assign unused_va_offset = ^va_i[11:0];

    function automatic logic [PLEN-1:0] pte_addr(input logic [21:0] ppn, input logic [9:0] vpn);
        logic [33:0] full;
        full = {ppn, 12'b0} + {22'b0, vpn, 2'b00};
        return PLEN'(full);
    endfunction

    logic [31:0] rsp_pte;
    if (DataWidth == 64) begin : g_sel64
        assign rsp_pte = mem_addr_q[2] ? mem_rsp_data_i[63:32] : mem_rsp_data_i[31:0];
    end else begin : g_sel32
        assign rsp_pte = mem_rsp_data_i[31:0];
    end

    logic pte_v, pte_r, pte_w, pte_x;
    logic rsp_leaf, rsp_fault, ppn0_nz;
    assign pte_v     = rsp_pte[0];
    assign pte_r     = rsp_pte[1];
    assign pte_w     = rsp_pte[2];
    assign pte_x     = rsp_pte[3];
    assign rsp_leaf  = pte_r | pte_x;
    assign rsp_fault = mem_rsp_error_i | ~pte_v | (~pte_r & pte_w);
    assign ppn0_nz   = |rsp_pte[19:10];

    logic cache_hit;
    logic [PLEN-1:0] hit_addr;

`ifdef SNITCH_PTW_PTR_CACHE_EN
    logic        cache_valid_q;
    logic [9:0]  cache_vpn1_q;
    logic [21:0] cache_ppn_q;
    logic [9:0]  vpn1_q;

    assign cache_hit = cache_valid_q && (cache_vpn1_q == va_i[31:22]);
    assign hit_addr  = pte_addr(cache_ppn_q, va_i[21:12]);

    // Only a clean, non-aborted level-1 pointer may populate the entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_valid_q <= 1'b0;
            cache_vpn1_q  <= '0;
            cache_ppn_q   <= '0;
            vpn1_q        <= '0;
        end else begin
            if (state_q == IDLE && valid_i && !flush_i) begin
                vpn1_q <= va_i[31:22];
            end
            if (flush_i) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == L1_WAIT && mem_rsp_valid_i && !abort_q
                         && !rsp_fault && !rsp_leaf) begin
                cache_valid_q <= 1'b1;
                cache_vpn1_q  <= vpn1_q;
                cache_ppn_q   <= rsp_pte[31:10];
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_addr  = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vpn0_q      <= '0;
            pte_q       <= '0;
            is_4mega_q  <= 1'b0;
            abort_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            // NOTE: default first so ready_q is a single-cycle pulse on entry to DONE.
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        vpn0_q      <= va_i[21:12];
                        mem_valid_q <= 1'b1;
                        if (cache_hit) begin
                            state_q    <= L0_REQ;
                            mem_addr_q <= hit_addr;
                        end else begin
                            state_q    <= L1_REQ;
                            mem_addr_q <= pte_addr(satp_ppn_i, va_i[31:22]);
                        end
                    end
                end
                L1_REQ, L0_REQ: begin
                    // An accepted request must still be drained, even under flush.
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        abort_q     <= flush_i;
                        state_q     <= (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                    end else if (flush_i) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                L1_WAIT, L0_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        abort_q <= 1'b0;
                        if (abort_q || flush_i) begin
                            state_q <= IDLE;
                        end else if (state_q == L1_WAIT && !rsp_fault && !rsp_leaf) begin
                            state_q     <= L0_REQ;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= pte_addr(rsp_pte[31:10], vpn0_q);
                        end else begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            if (state_q == L1_WAIT) begin
                                is_4mega_q <= ~mem_rsp_error_i & pte_v & rsp_leaf;
                                pte_q      <= (rsp_fault || ppn0_nz) ? (rsp_pte & ~ABitMask) : rsp_pte;
                            end else begin
                                is_4mega_q <= 1'b0;
                                pte_q      <= (rsp_fault || !rsp_leaf) ? (rsp_pte & ~ABitMask) : rsp_pte;
                            end
                        end
                    end else if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign pte_o       = pte_q;
    assign is_4mega_o  = is_4mega_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = mem_addr_q;

endmodule

// File: doc/snitch_ptw.md
Name: snitch_ptw

Overview:
- Sv32 hardware page-table walker that services refill requests from the L0 TLB.
- On a refill request it fetches the level-1 and, if needed, the level-0 PTE through a single-outstanding memory port.
- It returns the leaf PTE and a 4 MiB flag to the TLB.
- It sits directly downstream of the L0 TLB refill interface and upstream of the core's data/PTW memory arbiter.

Parameters:
- PLEN, 34, physical address width.
- DataWidth, 32, memory response width (32 or 64); for 64 the 32-bit PTE is selected by address bit 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  abort/invalidate (sfence.vma, satp write)
- satp_ppn_i  in  22  root page-table PPN
- valid_i  in  1  refill request from TLB, held until ready_o
- ready_o  out  1  one-cycle pulse: result valid this cycle
- va_i  in  32  virtual address to translate
- pte_o  out  32  Sv32 leaf PTE (ppn[31:10], flags[7:0])
- is_4mega_o  out  1  leaf found at level 1
- mem_valid_o  out  1  memory read request
- mem_ready_i  in  1  request accepted
- mem_addr_o  out  PLEN  PTE physical address
- mem_rsp_valid_i  in  1  read data valid
- mem_rsp_data_i  in  DataWidth  read data
- mem_rsp_error_i  in  1  bus error with response

Behaviour:
- Reset: state IDLE, all outputs 0, va/pte registers 0.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE.
- IDLE: valid_i=1 and flush_i=0 -> latch va_i, go to L1_REQ.
- L1_REQ: mem_valid_o=1, addr = {satp_ppn_i,12'b0} + vpn1*4, zero-extended/truncated to PLEN. Hold until mem_ready_i, then go to L1_WAIT.
- L0_REQ: addr = {pte.ppn,12'b0} + vpn0*4. Hold until mem_ready_i, then go to L0_WAIT.
- Request signals stay stable while mem_ready_i=0.
- WAIT states: capture the PTE on mem_rsp_valid_i.
- Level 1 decode:
  - Pointer (V=1, R=W=X=0) -> L0_REQ.
  - Leaf -> DONE with is_4mega=1.
  - Leaf with ppn0 != 0 (misaligned superpage) -> fault.
- Level 0 decode:
  - Leaf -> DONE, is_4mega=0.
  - Pointer -> fault.
- Fault conditions at either level: V=0, (R=0 and W=1), or mem_rsp_error_i.
- Fault handling: go to DONE with the captured PTE's A bit (bit 6) forced to 0, so the TLB hit raises a page fault. is_4mega as determined, 0 on error.
- DONE: ready_o=1, pte_o/is_4mega_o driven from registers, return to IDLE next cycle. ready_o is never asserted in any other state.
- Latency, memory always ready with 1-cycle response, counting from the cycle valid_i is first seen:
  - two-level walk: ready_o at cycle 5
  - superpage: ready_o at cycle 3
- flush_i in IDLE/DONE: no effect on the FSM; DONE still pulses.
- flush_i in L1_REQ/L0_REQ before acceptance: drop the request, go to IDLE.
- flush_i in a WAIT state: set an abort flag, wait for mem_rsp_valid_i, discard the data, go to IDLE without ready_o.
- After any flush, a still-asserted valid_i starts a fresh walk from IDLE with the new satp_ppn_i.
- At most one memory transaction is outstanding.
- Reset mid-walk returns to IDLE immediately; a later stray response is ignored in IDLE.

Optional Feature:
- SNITCH_PTW_PTR_CACHE_EN defined: a single-entry cache holds {valid, vpn1, next-level PPN} from the last valid level-1 pointer PTE.
  - In IDLE, a request whose vpn1 matches a valid entry goes directly to L0_REQ, skipping level 1 (two-level latency 3 cycles).
  - The entry is filled on a successful level-1 pointer decode.
  - It is cleared by flush_i and reset.
  - Faults never fill it.
- Undefined: no cache storage; every walk starts at L1_REQ.

Test Plan:
- Two-level walk: satp_ppn_i=0x00080, va_i=0x40001000.
  - Request at addr 0x80400, respond 0x00020401.
  - Request at addr 0x81004, respond 0x048D14CF.
  - Expect ready_o at cycle 5, pte_o=0x048D14CF, is_4mega_o=0.
- Superpage: same va, L1 response 0x001000CF -> one memory access; ready_o at cycle 3, pte_o=0x001000CF, is_4mega_o=1.
- Misaligned superpage: L1 response 0x001004CF -> pte_o=0x0010048F (A cleared), is_4mega_o=1. Invalid L1 PTE 0x00000000 -> pte_o=0x00000000.
- Backpressure: mem_ready_i low 4 cycles -> mem_valid_o/mem_addr_o stable at 0x80400. Bus error on L0 response -> ready_o with A=0, is_4mega_o=0.
- Flush: flush_i in L1_WAIT with valid_i held -> response discarded, no ready_o, new walk issues 0x80400 again.
- With SNITCH_PTW_PTR_CACHE_EN:
  - Repeat the two-level walk with va_i=0x40002000 -> first access at 0x81008, ready_o at cycle 3.
  - After flush_i -> the same request goes to 0x80400 again.
